// File: rtl/buffer_ram_stream_reader_pkg.sv
// Shared types and constants for the BufferRAM stream reader.
// Optional stride support is selected with BUFFER_READER_STRIDE_EN.
package buffer_ram_stream_reader_pkg;

    localparam int FSIZE                    = 64;
    localparam int BUFFER_READ_LATENCY      = 3;
    localparam int BUFFER_DEPTH             = 512;
    localparam int BUFFER_DEPTHAD           = $clog2(BUFFER_DEPTH);
    localparam int BUFFER_LENW              = $clog2(BUFFER_DEPTH) + 1;
    localparam int BUFFER_READER_SKID_DEPTH = BUFFER_READ_LATENCY + 2;

    typedef struct packed {
        logic [BUFFER_DEPTHAD-1:0] base_addr;
        logic [BUFFER_LENW-1:0]    length;
        logic [BUFFER_DEPTHAD-1:0] stride;
    } BufferReaderCmd;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } reader_state_t;

endpackage

// File: rtl/buffer_ram_stream_reader_skid_fifo.sv
// Skid FIFO holding {last, data} words returned by the RAM read pipe.
// Push and pop in the same cycle leave the count unchanged.
module buffer_reader_skid_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 5
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage, circular pointers and occupancy count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head_data = mem[rd_ptr];

    // The credit check upstream must make these impossible
    overflow_chk: assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && count == CW'(DEPTH)));
    underflow_chk: assert property (@(posedge clk) disable iff (!rstn)
        !(pop && count == '0));

endmodule

// File: rtl/buffer_ram_stream_reader.sv
// BufferRAM read engine: (base, length) command -> raddr sequence -> valid/ready stream.
// Define BUFFER_READER_STRIDE_EN to add the stride port (address step = stride).
module buffer_ram_stream_reader
    import buffer_ram_stream_reader_pkg::*;
#(
    parameter int DEPTH        = 512,
    parameter int WIDTH        = FSIZE,
    parameter int READ_LATENCY = BUFFER_READ_LATENCY,
    parameter int SKID_DEPTH   = READ_LATENCY + 2,
    parameter int DEPTHAD      = $clog2(DEPTH),
    parameter int LENW         = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [DEPTHAD-1:0] base_addr,
    input  logic [LENW-1:0]    length,
    output logic               busy,
    output logic               done,
    output logic [DEPTHAD-1:0] ram_raddr,
    input  logic [WIDTH-1:0]   ram_rdata,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_last
`ifdef BUFFER_READER_STRIDE_EN
    ,
    input  logic [DEPTHAD-1:0] stride
`endif
);

    localparam int CW = $clog2(SKID_DEPTH + 1);

    reader_state_t           state;
    logic [LENW-1:0]         remaining;
    logic [DEPTHAD-1:0]      step;
    logic [READ_LATENCY-1:0] vpipe;
    logic [READ_LATENCY-1:0] lpipe;
    logic [CW-1:0]           fifo_count;
    logic [CW-1:0]           inflight;
    logic                    credit_ok;
    logic                    issue;
    logic                    pop;
    logic                    fire_last;
    logic [DEPTHAD:0]        addr_sum;
    logic [DEPTHAD-1:0]      next_addr;
    logic [WIDTH:0]          head;

`ifdef BUFFER_READER_STRIDE_EN
    // Latch the address step with the command
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            step <= '0;
        end else if (state == S_IDLE && start) begin
            step <= stride;
        end
    end
`else
    assign step = DEPTHAD'(1);
`endif

    // Credit check, modulo-DEPTH address step and stream handshake decode
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(vpipe[i]);
        end
        credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(SKID_DEPTH);
        issue     = (state == S_ISSUE) && credit_ok;
        addr_sum  = {1'b0, ram_raddr} + {1'b0, step};
        next_addr = (addr_sum >= (DEPTHAD + 1)'(DEPTH))
                  ? DEPTHAD'(addr_sum - (DEPTHAD + 1)'(DEPTH))
                  : addr_sum[DEPTHAD-1:0];
        pop       = m_valid && m_ready;
        fire_last = pop && m_last;
    end

    // Command FSM with registered busy/done and address generator
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_raddr <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ram_raddr <= base_addr;
                        remaining <= length;
                        busy      <= 1'b1;
                        state     <= (length == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        ram_raddr <= next_addr;
                        remaining <= remaining - 1'b1;
                        if (remaining == LENW'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (inflight == '0 && fire_last) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // An empty command arrives here without the pulse armed,
                    // so it spends one extra cycle raising done.
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Valid/last tags travelling alongside each outstanding read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vpipe <= '0;
            lpipe <= '0;
        end else begin
            vpipe[0] <= issue;
            lpipe[0] <= issue && (remaining == LENW'(1));
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                vpipe[i] <= vpipe[i-1];
                lpipe[i] <= lpipe[i-1];
            end
        end
    end

    buffer_reader_skid_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (SKID_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (vpipe[READ_LATENCY-1]),
        .push_data ({lpipe[READ_LATENCY-1], ram_rdata}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count)
    );

    assign m_valid = (fifo_count != '0);
    assign m_data  = head[WIDTH-1:0];
    assign m_last  = m_valid && head[WIDTH];

endmodule

// File: tb/tb_buffer_ram_stream_reader.sv
// Scoreboard bench: BufferRAM model (DEPTH=16, latency 3, mem[i]=i+100) + reader.
module tb_buffer_ram_stream_reader;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;
    localparam int RL    = 3;
    localparam int AW    = 4;
    localparam int LW    = 5;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [LW-1:0]    length;
    logic             busy;
    logic             done;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
`ifdef BUFFER_READER_STRIDE_EN
    logic [AW-1:0]    stride;
`endif

    always #5 clk = ~clk;

    buffer_ram_stream_reader #(
        .DEPTH        (DEPTH),
        .WIDTH        (WIDTH),
        .READ_LATENCY (RL),
        .SKID_DEPTH   (RL + 2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
`ifdef BUFFER_READER_STRIDE_EN
        ,
        .stride    (stride)
`endif
    );

    // BufferRAM model: fixed 3-cycle read latency
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rpipe [RL];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(100 + i);
    always @(posedge clk) begin
        rpipe[0] <= mem[ram_raddr];
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_rdata = rpipe[RL-1];

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    int first_valid = -1;
    int last_cyc = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int beats = 0;
    int max_count = 0;
    int issues = 0;
    bit rand_ready = 0;
    logic [WIDTH:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, tracks timing events
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (dut.issue) issues++;
            if (int'(dut.fifo_count) > max_count) max_count = int'(dut.fifo_count);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_valid && first_valid < 0) first_valid = cyc - t0;
            if (m_valid && m_ready) begin
                beats++;
                if (m_last) last_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL extra_beat: got data %0d last %0d, expected no beat", m_data, m_last);
                end else begin
                    logic [WIDTH:0] e;
                    e = exp_q.pop_front();
                    check("beat_last_data", int'({m_last, m_data}), int'(e));
                end
            end
        end
    end

    // Random backpressure: ready low about 30% of cycles
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            m_ready = ($urandom_range(0, 99) >= 30);
        end
    end

    task automatic start_cmd(input int b, input int len, input int st);
        @(posedge clk);
        #1;
        base_addr = AW'(b);
        length    = LW'(len);
`ifdef BUFFER_READER_STRIDE_EN
        stride    = AW'(st);
`endif
        start       = 1'b1;
        t0          = cyc;
        first_valid = -1;
        last_cyc    = -1;
        beats       = 0;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, WIDTH'(100 + (b + i * st) % DEPTH)});
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done(input int snap, input int budget);
        int n;
        n = 0;
        while (done_cnt == snap && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("done_pulse_count", done_cnt - snap, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        check("busy_after_done", int'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_m_valid"}, int'(m_valid), 0);
        check({tag, "_m_last"}, int'(m_last), 0);
        check({tag, "_ram_raddr"}, int'(ram_raddr), 0);
        check({tag, "_m_data"}, int'(m_data), 0);
    endtask

    initial begin
        int snap;
        int isnap;
        rstn = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        m_ready = 1'b1;
`ifdef BUFFER_READER_STRIDE_EN
        stride = '0;
`endif
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // 1: base=2 len=4, ready held high
        snap = done_cnt;
        start_cmd(2, 4, 1);
        wait_done(snap, 100);
        check("t1_first_valid_cycle", first_valid, 5);
        check("t1_last_beat_cycle", last_cyc - t0, 8);
        check("t1_done_after_last", done_cyc - last_cyc, 1);
        check("t1_beats", beats, 4);

        // 2: wrap-around, plus a start pulse while busy that must be ignored
        snap = done_cnt;
        start_cmd(14, 4, 1);
        @(posedge clk);
        #1;
        base_addr = AW'(9);
        length    = LW'(3);
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(snap, 100);
        repeat (10) @(negedge clk);
        check("t2_first_valid_cycle", first_valid, 5);
        check("t2_no_gap_last_cycle", last_cyc - t0, 8);
        check("t2_beats_ignore_busy_start", beats, 4);
        check("t2_done_once", done_cnt - snap, 1);

        // 3: len=8 under random backpressure
        snap = done_cnt;
        max_count = 0;
        rand_ready = 1'b1;
        start_cmd(5, 8, 1);
        wait_done(snap, 600);
        rand_ready = 1'b0;
        #3 m_ready = 1'b1;
        check("t3_beats", beats, 8);
        check("t3_fifo_count_le_5", int'(max_count <= 5), 1);

        // 4: zero-length command
        snap = done_cnt;
        isnap = issues;
        start_cmd(7, 0, 1);
        wait_done(snap, 50);
        check("t4_done_cycle", done_cyc - t0, 2);
        check("t4_no_valid", first_valid, -1);
        check("t4_no_reads", issues - isnap, 0);

        // 5: reset while draining, then a fresh command
        snap = done_cnt;
        m_ready = 1'b0;
        start_cmd(3, 3, 1);
        repeat (5) @(posedge clk);
        #1 rstn = 1'b0;
        exp_q.delete();
        #2;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        m_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_no_done_abandoned", done_cnt - snap, 0);
        snap = done_cnt;
        start_cmd(0, 2, 1);
        wait_done(snap, 100);
        check("t5_beats", beats, 2);

`ifdef BUFFER_READER_STRIDE_EN
        // 6: strided read with wrap (1,6,11,0)
        snap = done_cnt;
        start_cmd(1, 4, 5);
        wait_done(snap, 100);
        check("t6_beats", beats, 4);
        check("t6_first_valid_cycle", first_valid, 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1);
    end

endmodule
